uart_rx16: RTL and testbench

Receive-side counterpart of the team's 16-bit UART transmitter. It recovers the 16-bit frame format: idle-high line, one start bit (0), 16 data bits LSB first, one stop bit (1). The block samples the serial line with an oversampled clock and rejects glitches on the start bit. It presents each received word on a valid/ready handshake toward the matrix-multiplication datapath, and flags framing and overrun errors.

---
 rtl/uart_rx16.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx16.sv
// uart_rx16: 16-bit UART receiver with oversampled line sampling.
// Frame: start bit (0), 16 data bits LSB first, one stop bit (1).
// A received word is offered on a valid/ready handshake; framing and
// overrun problems are reported as single-cycle pulses.
module uart_rx16 #(
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] data,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        busy,
   output logic        frame_err,
   output logic        overrun_err
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   // Last tick of the half-bit wait that lands on the start-bit centre.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   // Last tick of a full bit period.
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [3:0]       bit_idx;
   logic [3:0]       bit_idx_nx;
   logic [15:0]      shift;
   logic [15:0]      shift_nx;
   logic [15:0]      data_nx;
   logic             data_valid_nx;
   logic             busy_nx;
   logic             frame_err_nx;
   logic             overrun_err_nx;
   logic             rx_m;
   logic             rx_s;
   logic             pop;

   // The consumer takes the held word on this edge.
   assign pop = data_valid & data_ready;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Next-state, datapath and output computation for the receive FSM.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      bit_idx_nx     = bit_idx;
      shift_nx       = shift;
      data_nx        = data;
      data_valid_nx  = data_valid;
      frame_err_nx   = 1'b0;
      overrun_err_nx = 1'b0;

      // A pop is applied before any completion on the same edge, so a
      // completing frame below sees the freed slot.
      if (pop) begin
         data_valid_nx = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nx = S_START;
               cnt_nx   = '0;
            end
         end

         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  // Line went back high before mid start bit: glitch.
                  state_nx = S_IDLE;
               end else begin
                  state_nx   = S_DATA;
                  bit_idx_nx = '0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx   = '0;
               shift_nx = {rx_s, shift[15:1]};
               if (bit_idx == 4'd15) begin
                  state_nx   = S_STOP;
                  bit_idx_nx = '0;
               end else begin
                  bit_idx_nx = bit_idx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  state_nx = S_IDLE;
                  if (data_valid && !data_ready) begin
                     // Previous word still unconsumed: keep it, drop new one.
                     overrun_err_nx = 1'b1;
                  end else begin
                     data_nx       = shift;
                     data_valid_nx = 1'b1;
                  end
               end else begin
                  frame_err_nx = 1'b1;
                  state_nx     = S_BREAK;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_BREAK: begin
            // Wait out a held-low line so it raises only one frame_err.
            if (rx_s) begin
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase

      busy_nx = (state_nx != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         data        <= '0;
         data_valid  <= 1'b0;
         busy        <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         bit_idx     <= bit_idx_nx;
         shift       <= shift_nx;
         data        <= data_nx;
         data_valid  <= data_valid_nx;
         busy        <= busy_nx;
         frame_err   <= frame_err_nx;
         overrun_err <= overrun_err_nx;
      end
   end

endmodule

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16: directed self-checking bench for uart_rx16.
module tb_uart_rx16;

   logic        clk;
   logic        rst_n;
   logic        rx;
   logic [15:0] data;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        frame_err;
   logic        overrun_err;

   int total;
   int bad;
   int cyc;
   int e0_cyc;
   int rise_cyc;
   int ferr_cnt;
   int ovr_cnt;
   logic dv_prev;
   logic [15:0] popped[$];

   typedef struct {
      logic [15:0] word;
      logic        stop;
      logic        exp_valid;
      logic        exp_busy;
      int          exp_ferr;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   uart_rx16 #(.OVERSAMPLE(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .data        (data),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun_err) ovr_cnt = ovr_cnt + 1;
      if (data_valid && data_ready) popped.push_back(data);
      if (data_valid && !dv_prev) rise_cyc = cyc;
      dv_prev = data_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; entered and left 1 time unit after a clock edge.
   task automatic send_bits(input logic [15:0] w, input logic stop);
      rx = 1'b0;
      @(posedge clk);
      #1 e0_cyc = cyc;
      repeat (15) @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         rx = w[i];
         repeat (16) @(posedge clk);
         #1;
      end
      rx = stop;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      data_ready = 1'b1;
      @(posedge clk);
      #1 data_ready = 1'b0;
   endtask

   initial begin
      int f0;
      int o0;
      int base;
      logic [15:0] b2b[3];

      total = 0; bad = 0; cyc = 0; e0_cyc = 0; rise_cyc = 0;
      ferr_cnt = 0; ovr_cnt = 0; dv_prev = 1'b0;
      rx = 1'b1; data_ready = 1'b0; rst_n = 1'b0;

      vecs[0] = '{16'hA5C3, 1'b1, 1'b1, 1'b0, 0, 16'hA5C3};
      vecs[1] = '{16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'h0000};
      vecs[2] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 0, 16'hFFFF};
      vecs[3] = '{16'h1357, 1'b0, 1'b0, 1'b1, 1, 16'hFFFF};
      vecs[4] = '{16'h8001, 1'b1, 1'b1, 1'b0, 0, 16'h8001};
      vecs[5] = '{16'h7E81, 1'b1, 1'b1, 1'b0, 0, 16'h7E81};

      // Reset held with a toggling line.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 rx = ~rx;
         check("reset busy", {31'd0, busy}, 32'd0);
         check("reset valid", {31'd0, data_valid}, 32'd0);
      end
      check("reset data", {16'd0, data}, 32'd0);
      rx = 1'b1;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(40);
      check("idle after release busy", {31'd0, busy}, 32'd0);
      check("idle after release valid", {31'd0, data_valid}, 32'd0);
      check("reset no frame_err", ferr_cnt, 0);
      check("reset no overrun_err", ovr_cnt, 0);

      // Table of single frames, consumer stalled during reception.
      for (int k = 0; k < 6; k++) begin
         data_ready = 1'b0;
         f0 = ferr_cnt;
         o0 = ovr_cnt;
         send_bits(vecs[k].word, vecs[k].stop);
         check("vec busy end of stop", {31'd0, busy}, {31'd0, vecs[k].exp_busy});
         rx = 1'b1;
         wait_cycles(4);
         check("vec valid", {31'd0, data_valid}, {31'd0, vecs[k].exp_valid});
         check("vec data", {16'd0, data}, {16'd0, vecs[k].exp_data});
         check("vec frame_err count", ferr_cnt - f0, vecs[k].exp_ferr);
         check("vec overrun count", ovr_cnt - o0, 0);
         check("vec busy after", {31'd0, busy}, 32'd0);
         if (vecs[k].exp_valid) begin
            check("vec valid latency", rise_cyc - e0_cyc, 282);
            wait_cycles(5);
            check("vec valid held", {31'd0, data_valid}, 32'd1);
            pop_one();
            check("vec valid cleared", {31'd0, data_valid}, 32'd0);
            check("vec data after pop", {16'd0, data}, {16'd0, vecs[k].exp_data});
         end
      end

      // Back-to-back frames, consumer always ready.
      b2b[0] = 16'h0001; b2b[1] = 16'hFFFF; b2b[2] = 16'h8000;
      base = popped.size();
      f0 = ferr_cnt; o0 = ovr_cnt;
      data_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bits(b2b[i], 1'b1);
      wait_cycles(20);
      data_ready = 1'b0;
      check("b2b count", popped.size() - base, 3);
      for (int i = 0; i < 3; i++) begin
         if (popped.size() > base + i)
            check("b2b word", {16'd0, popped[base + i]}, {16'd0, b2b[i]});
      end
      check("b2b frame_err", ferr_cnt - f0, 0);
      check("b2b overrun", ovr_cnt - o0, 0);

      // Short low glitch on an idle line.
      f0 = ferr_cnt; o0 = ovr_cnt;
      rx = 1'b0;
      wait_cycles(4);
      rx = 1'b1;
      wait_cycles(2);
      check("glitch busy in start", {31'd0, busy}, 32'd1);
      wait_cycles(10);
      check("glitch busy after check", {31'd0, busy}, 32'd0);
      wait_cycles(300);
      check("glitch no data", {31'd0, data_valid}, 32'd0);
      check("glitch no errors", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

      // 40-bit-period break.
      f0 = ferr_cnt;
      rx = 1'b0;
      wait_cycles(640);
      check("break busy while low", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_cycles(10);
      check("break one frame_err", ferr_cnt - f0, 1);
      check("break no data", {31'd0, data_valid}, 32'd0);
      check("break busy after", {31'd0, busy}, 32'd0);

      // Overrun with stalled consumer.
      o0 = ovr_cnt;
      send_bits(16'h1234, 1'b1);
      wait_cycles(2);
      check("ovr first word", {16'd0, data}, 32'h1234);
      send_bits(16'h5678, 1'b1);
      wait_cycles(4);
      check("ovr pulse count", ovr_cnt - o0, 1);
      check("ovr data kept", {16'd0, data}, 32'h1234);
      check("ovr valid kept", {31'd0, data_valid}, 32'd1);
      pop_one();

      // Pop on the completion edge of the second frame.
      send_bits(16'h1234, 1'b1);
      wait_cycles(2);
      o0 = ovr_cnt;
      fork
         send_bits(16'h5678, 1'b1);
         begin
            repeat (282) @(posedge clk);
            #1 data_ready = 1'b1;
            @(posedge clk);
            #1 data_ready = 1'b0;
         end
      join
      wait_cycles(4);
      check("same-edge data", {16'd0, data}, 32'h5678);
      check("same-edge valid", {31'd0, data_valid}, 32'd1);
      check("same-edge no overrun", ovr_cnt - o0, 0);
      pop_one();
      check("same-edge valid popped", {31'd0, data_valid}, 32'd0);

      // Reset in the middle of a frame.
      base = popped.size();
      fork
         send_bits(16'h3C5A, 1'b1);
         begin
            repeat (130) @(posedge clk);
            #1 rst_n = 1'b0;
            wait_cycles(3);
            check("midreset busy", {31'd0, busy}, 32'd0);
            check("midreset data", {16'd0, data}, 32'd0);
         end
      join
      wait_cycles(4);
      rst_n = 1'b1;
      wait_cycles(4);
      send_bits(16'h00FF, 1'b1);
      wait_cycles(4);
      check("midreset new word", {16'd0, data}, 32'h00FF);
      check("midreset new valid", {31'd0, data_valid}, 32'd1);
      pop_one();
      check("midreset delivered count", popped.size() - base, 1);
      if (popped.size() > base)
         check("midreset delivered word", {16'd0, popped[base]}, 32'h00FF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
